// File: rtl/data_mem_io.sv
// Data-side memory and I/O block: word-addressed RAM plus LED, switch, cycle counter
// and reload timer registers, with zero-latency read data for the pipeline MEM stage.
module data_mem_io #(
    parameter int RAM_WORDS   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic        MemRW,
    output logic [31:0] Data_out,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic        err
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] SW_ADDR     = 32'hFFFF_0004;
    localparam logic [31:0] CNT_ADDR    = 32'hFFFF_0008;
    localparam logic [31:0] RELOAD_ADDR = 32'hFFFF_000C;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0010;

    logic [31:0]   word_addr_s;
    logic          ram_hit_s;
    logic          io_hit_s;
    logic          unmapped_s;
    logic [AW-1:0] ram_idx_s;
    logic          wr_ram_s;
    logic          wr_led_s;
    logic          wr_reload_s;
    logic          wr_status_s;
    logic          expire_s;
    logic [31:0]   count_nxt_s;
    logic          expired_nxt_s;
    logic [31:0]   rdata_s;

    logic [31:0] ram_r [RAM_WORDS];
    logic [15:0] sync_r [SYNC_STAGES];
    logic [15:0] led_r;
    logic [31:0] cycle_cnt_r;
    logic [31:0] reload_r;
    logic [31:0] count_r;
    logic        expired_r;
    logic        err_r;

    // Address decode and write strobes; the byte offset is masked off before decoding.
    always_comb begin
        word_addr_s = Addr_in & 32'hFFFF_FFFC;
        ram_hit_s   = (Addr_in[31:10] == 22'h0);
        io_hit_s    = (word_addr_s == LED_ADDR)    || (word_addr_s == SW_ADDR) ||
                      (word_addr_s == CNT_ADDR)    || (word_addr_s == RELOAD_ADDR) ||
                      (word_addr_s == STATUS_ADDR);
        unmapped_s  = !(ram_hit_s || io_hit_s);
        ram_idx_s   = Addr_in[AW+1:2];
        wr_ram_s    = MemRW && ram_hit_s;
        wr_led_s    = MemRW && (word_addr_s == LED_ADDR);
        wr_reload_s = MemRW && (word_addr_s == RELOAD_ADDR);
        wr_status_s = MemRW && (word_addr_s == STATUS_ADDR);
    end

    // Timer next state: a reload write overrides decrement/expiry, and expiry beats a clear.
    always_comb begin
        count_nxt_s   = count_r;
        expired_nxt_s = expired_r;
        expire_s      = !wr_reload_s && (reload_r != 32'h0) && (count_r == 32'h0);
        if (wr_reload_s) begin
            count_nxt_s = Data_in;
        end else if (reload_r != 32'h0) begin
            if (count_r != 32'h0) begin
                count_nxt_s = count_r - 32'd1;
            end else begin
                count_nxt_s = reload_r;
            end
        end else begin
            count_nxt_s = 32'h0;
        end
        if (expire_s) begin
            expired_nxt_s = 1'b1;
        end else if (wr_status_s && Data_in[0]) begin
            expired_nxt_s = 1'b0;
        end else begin
            expired_nxt_s = expired_r;
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        rdata_s = 32'h0;
        if (ram_hit_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else begin
            case (word_addr_s)
                LED_ADDR:    rdata_s = {16'h0, led_r};
                SW_ADDR:     rdata_s = {16'h0, sync_r[SYNC_STAGES-1]};
                CNT_ADDR:    rdata_s = cycle_cnt_r;
                RELOAD_ADDR: rdata_s = reload_r;
                STATUS_ADDR: rdata_s = {31'h0, expired_r};
                default:     rdata_s = 32'h0;
            endcase
        end
    end

    // RAM array: synchronous write, not cleared by reset, frozen while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && wr_ram_s) begin
            ram_r[ram_idx_s] <= Data_in;
        end
    end

    // Switch synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 16'h0;
            end
        end else begin
            sync_r[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // LED register, free-running cycle counter, timer and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r       <= 16'h0;
            cycle_cnt_r <= 32'h0;
            reload_r    <= 32'h0;
            count_r     <= 32'h0;
            expired_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (wr_led_s) begin
                led_r <= Data_in[15:0];
            end
            if (wr_reload_s) begin
                reload_r <= Data_in;
            end
            if (unmapped_s) begin
                err_r <= 1'b1;
            end
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            count_r     <= count_nxt_s;
            expired_r   <= expired_nxt_s;
        end
    end

    assign Data_out  = rdata_s;
    assign led       = led_r;
    assign timer_irq = expired_r;
    assign err       = err_r;

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed scenarios followed by random traffic
// checked against a behavioural model of the memory map.
module tb_data_mem_io;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic        MemRW;
    logic [31:0] Data_out;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_ram [256];
    bit          m_valid [256];
    logic [15:0] m_led, m_sw0, m_sw1;
    logic [31:0] m_cnt, m_reload, m_count;
    logic        m_exp, m_err;
    logic [31:0] last_dout;

    data_mem_io #(.RAM_WORDS(256), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .Addr_in(Addr_in), .Data_in(Data_in), .MemRW(MemRW),
        .Data_out(Data_out), .sw(sw), .led(led), .timer_irq(timer_irq), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 RAM, 1 LED, 2 switches, 3 counter, 4 reload, 5 status, -1 unmapped
    function automatic int kind_of(input logic [31:0] a);
        if (a < 32'h0000_0400) return 0;
        case (a & 32'hFFFF_FFFC)
            32'hFFFF_0000: return 1;
            32'hFFFF_0004: return 2;
            32'hFFFF_0008: return 3;
            32'hFFFF_000C: return 4;
            32'hFFFF_0010: return 5;
            default:       return -1;
        endcase
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        int k;
        logic [7:0] idx;
        k = kind_of(a);
        idx = a[9:2];
        known = 1'b1;
        case (k)
            0: begin v = m_ram[idx]; known = m_valid[idx]; end
            1: v = {16'h0, m_led};
            2: v = {16'h0, m_sw1};
            3: v = m_cnt;
            4: v = m_reload;
            5: v = {31'h0, m_exp};
            default: v = 32'h0;
        endcase
    endtask

    task automatic model_reset();
        m_led = 16'h0; m_sw0 = 16'h0; m_sw1 = 16'h0;
        m_cnt = 32'h0; m_reload = 32'h0; m_count = 32'h0;
        m_exp = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic rw);
        int k;
        bit wr_rel, wr_stat, expire;
        logic [7:0] idx;
        k = kind_of(a);
        idx = a[9:2];
        wr_rel  = rw && (k == 4);
        wr_stat = rw && (k == 5);
        expire  = !wr_rel && (m_reload != 0) && (m_count == 0);
        if (k < 0) m_err = 1'b1;
        if (rw && k == 0) begin m_ram[idx] = d; m_valid[idx] = 1'b1; end
        if (rw && k == 1) m_led = d[15:0];
        if (wr_rel) begin
            m_reload = d; m_count = d;
        end else if (m_reload == 0) begin
            m_count = 0;
        end else if (m_count == 0) begin
            m_count = m_reload;
        end else begin
            m_count = m_count - 1;
        end
        if (expire) m_exp = 1'b1;
        else if (wr_stat && d[0]) m_exp = 1'b0;
        m_cnt = m_cnt + 1;
        m_sw1 = m_sw0;
        m_sw0 = sw;
    endtask

    // One bus cycle: present inputs, check read data before the edge, check registers after.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic rw);
        logic [31:0] ev;
        bit known;
        Addr_in = a; Data_in = d; MemRW = rw;
        #1;
        last_dout = Data_out;
        model_read(a, ev, known);
        if (known) chk("data_out", Data_out, ev);
        @(posedge clk);
        model_edge(a, d, rw);
        #1;
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_exp});
        chk("err", {31'h0, err}, {31'h0, m_err});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        Addr_in = 32'h0; MemRW = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic rw;
        int r;
        bit found;
        rst = 1'b1; Addr_in = 32'h0; Data_in = 32'h0; MemRW = 1'b0; sw = 16'h0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        model_reset();
        #2;
        chk("init_led", {16'h0, led}, 32'h0);
        chk("init_irq", {31'h0, timer_irq}, 32'h0);
        chk("init_err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cycle counter: 10 edges after release it reads 10
        for (int i = 0; i < 11; i++) cycle(32'hFFFF_0008, 32'h0, 1'b0);
        chk("cnt_cycle10", last_dout, 32'd10);

        // LED write/read and switch synchronizer latency
        cycle(32'hFFFF_0000, 32'h0001_A5A5, 1'b1);
        chk("led_a5a5", {16'h0, led}, 32'h0000_A5A5);
        cycle(32'hFFFF_0000, 32'h0, 1'b0);
        chk("led_read", last_dout, 32'h0000_A5A5);
        sw = 16'h1234;
        cycle(32'hFFFF_0004, 32'h0, 1'b0);
        chk("sw_lat0", last_dout, 32'h0);
        cycle(32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1);
        chk("sw_lat1", last_dout, 32'h0);
        cycle(32'hFFFF_0004, 32'h0, 1'b0);
        chk("sw_lat2", last_dout, 32'h0000_1234);

        // Timer: reload 3 counts 3,2,1,0 then expires; clear; clear racing expiry
        cycle(32'hFFFF_000C, 32'd3, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'hFFFF_0010, 32'h0, 1'b0);
        chk("tmr_not_yet", {31'h0, timer_irq}, 32'h0);
        cycle(32'hFFFF_000C, 32'h0, 1'b0);
        chk("tmr_expire", {31'h0, timer_irq}, 32'h1);
        chk("tmr_reload_rd", last_dout, 32'd3);
        cycle(32'hFFFF_0010, 32'h1, 1'b1);
        chk("tmr_clear", {31'h0, timer_irq}, 32'h0);
        for (int i = 0; i < 2; i++) cycle(32'hFFFF_0010, 32'h0, 1'b0);
        cycle(32'hFFFF_0010, 32'h1, 1'b1);
        chk("tmr_clear_vs_expire", {31'h0, timer_irq}, 32'h1);

        // RAM word write/read with ignored byte offset, then unmapped access
        cycle(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        cycle(32'h0000_0010, 32'h0, 1'b0);
        chk("ram_10", last_dout, 32'hDEAD_BEEF);
        cycle(32'h0000_0013, 32'h0, 1'b0);
        chk("ram_13", last_dout, 32'hDEAD_BEEF);
        cycle(32'h0000_0410, 32'h0, 1'b0);
        chk("unmapped_rd", last_dout, 32'h0);
        chk("unmapped_err", {31'h0, err}, 32'h1);

        // Asynchronous reset while count is 2 with all LEDs lit
        cycle(32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_count == 32'd2) found = 1'b1;
            else cycle(32'h0000_0010, 32'h0, 1'b0);
        end
        chk("reach_count2", {31'h0, found}, 32'h1);
        do_reset();
        cycle(32'h0000_0010, 32'h0, 1'b0);
        chk("ram_after_rst", last_dout, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) cycle(32'hFFFF_0010, 32'h0, 1'b0);
        chk("tmr_idle_after_rst", {31'h0, timer_irq}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      a = $urandom_range(0, 32'h3FF);
            else if (r < 97) a = 32'hFFFF_0000 + 4 * $urandom_range(0, 4) + $urandom_range(0, 3);
            else if (r < 99) a = 32'h0000_0400 + $urandom_range(0, 32'hFFFF);
            else             a = 32'hFFFF_0014;
            rw = 1'($urandom_range(0, 1));
            if (kind_of(a) == 4) d = $urandom_range(0, 6);
            else                 d = $urandom;
            if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
            cycle(a, d, rw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
